// File: rtl/pmod_link_pkg.sv
// Shared role encodings and default sizing for the two-board Pmod link bridge.
package pmod_link_pkg;

  typedef enum logic [1:0] {
    ROLE_GUARD  = 2'd0,
    ROLE_MASTER = 2'd1,
    ROLE_SLAVE  = 2'd2
  } role_e;

  localparam int DEF_NCH           = 7;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_GUARD_CYCLES  = 16;

endpackage

// File: rtl/link_glitch_filter.sv
// Single-channel level filter: q follows d only after d has differed from q
// for STABLE_CYCLES consecutive enabled cycles.
module link_glitch_filter
  import pmod_link_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  localparam int            CW     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  // cnt tops out at STABLE_CYCLES-1, so it can never wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (en) begin
      if (d == q) begin
        cnt <= '0;
      end else if (cnt_inc == CNT_TC) begin
        q   <= d;
        cnt <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/pmod_link_bridge.sv
// Two-board Pmod link bridge with master/slave role select and a guard interval
// (all outputs low) after reset and on every role change.
//
//   state       | meaning
//   ROLE_GUARD  | outputs held low, guard counter running down to the new role
//   ROLE_MASTER | drive local OLED signals out, filter remote buttons in
//   ROLE_SLAVE  | drive local buttons out, pass remote OLED signals in
module pmod_link_bridge
  import pmod_link_pkg::*;
#(
  parameter int NCH           = DEF_NCH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           isMaster,
  input  logic [NCH-1:0] linkIn,
  output logic [NCH-1:0] linkOut,
  input  logic [NCH-1:0] masterTx,
  output logic [NCH-1:0] masterRx,
  input  logic [NCH-1:0] slaveTx,
  output logic [NCH-1:0] slaveRx,
  output logic [1:0]     roleState,
  output logic           guardActive
);

  localparam int            GW         = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

  logic [1:0]     role_sr;
  logic           role_sync;
  logic           role_q;
  logic [2:0]     role_vld_sr;
  logic           role_changed;
  logic [NCH-1:0] link_sr [SYNC_STAGES];
  logic [NCH-1:0] stx_sr  [SYNC_STAGES];
  logic [NCH-1:0] link_sync;
  logic [NCH-1:0] stx_sync;
  logic [NCH-1:0] filt_q;
  logic           filt_clr;
  logic           filt_en;
  role_e          state;
  logic [GW-1:0]  guard_cnt;

  assign role_sync = role_sr[1];
  assign link_sync = link_sr[SYNC_STAGES-1];
  assign stx_sync  = stx_sr[SYNC_STAGES-1];

  // The role synchroniser fills from its reset value of 0 over the first
  // cycles; that fill is not a real role change and must not stretch the guard.
  assign role_changed = role_vld_sr[2] && (role_sync != role_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      role_sr     <= '0;
      role_q      <= 1'b0;
      role_vld_sr <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        link_sr[i] <= '0;
        stx_sr[i]  <= '0;
      end
    end else begin
      role_sr     <= {role_sr[0], isMaster};
      role_q      <= role_sync;
      role_vld_sr <= {role_vld_sr[1:0], 1'b1};
      link_sr[0]  <= linkIn;
      stx_sr[0]   <= slaveTx;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        link_sr[i] <= link_sr[i-1];
        stx_sr[i]  <= stx_sr[i-1];
      end
    end
  end

  assign filt_clr = (state == ROLE_GUARD);
  assign filt_en  = (state == ROLE_MASTER);

  for (genvar c = 0; c < NCH; c++) begin : g_filt
    link_glitch_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filt (
      .clk (clk),
      .rstn(rstn),
      .clr (filt_clr),
      .en  (filt_en),
      .d   (link_sync[c]),
      .q   (filt_q[c])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ROLE_GUARD;
      guard_cnt <= GUARD_LOAD;
      linkOut   <= '0;
      masterRx  <= '0;
      slaveRx   <= '0;
    end else begin
      case (state)
        ROLE_GUARD: begin
          linkOut  <= '0;
          masterRx <= '0;
          slaveRx  <= '0;
          if (role_changed) begin
            guard_cnt <= GUARD_LOAD;
          end else if (guard_cnt <= GW'(1)) begin
            guard_cnt <= '0;
            state     <= role_sync ? ROLE_MASTER : ROLE_SLAVE;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        ROLE_MASTER: begin
          linkOut  <= masterTx;
          masterRx <= filt_q;
          slaveRx  <= '0;
          if (!role_sync) begin
            state     <= ROLE_GUARD;
            guard_cnt <= GUARD_LOAD;
          end
        end
        ROLE_SLAVE: begin
          linkOut  <= stx_sync;
          masterRx <= '0;
          slaveRx  <= link_sync;
          if (role_sync) begin
            state     <= ROLE_GUARD;
            guard_cnt <= GUARD_LOAD;
          end
        end
        default: begin
          state     <= ROLE_GUARD;
          guard_cnt <= GUARD_LOAD;
          linkOut   <= '0;
          masterRx  <= '0;
          slaveRx   <= '0;
        end
      endcase
    end
  end

  assign roleState   = state;
  assign guardActive = (state == ROLE_GUARD);

endmodule
